// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/bubble/forwarding control plus halt-drain and memory-wait FSM
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int MEM_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_dec,
    input  logic [4:0]  rs2_dec,
    input  logic        rs1_used_dec,
    input  logic        rs2_used_dec,
    input  logic [4:0]  rs1_exec,
    input  logic [4:0]  rs2_exec,
    input  logic [4:0]  rd_exec,
    input  logic [4:0]  rd_mem,
    input  logic [4:0]  rd_wb,
    input  logic        wen_exec,
    input  logic        wen_mem,
    input  logic        wen_wb,
    input  logic        load_exec,
    input  logic        redirect_mem,
    input  logic        halt_if,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        stall_if,
    output logic        stall_dec,
    output logic        bubble_exec,
    output logic        flush_dec,
    output logic        flush_exec,
    output logic        flush_mem,
    output logic        freeze,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic        halt_out,
    output logic        err_timeout,
    output logic [1:0]  state,
    output logic [15:0] stall_count
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    typedef enum logic [1:0] {RUN = 2'd0, MEMWAIT = 2'd1, DRAIN = 2'd2, HALTED = 2'd3} state_t;
    state_t        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          from_drain_q, from_drain_d;
    logic          halt_q, halt_d;
    logic          err_q, err_d;
    logic [15:0]   stall_cnt_q, stall_cnt_d;
    logic [1:0]    fwd_a, fwd_b;
    logic          lu, mw, draining;
    assign fwd_a = (wen_mem && rd_mem != 5'd0 && rd_mem == rs1_exec) ? 2'b01 :
                   (wen_wb && rd_wb != 5'd0 && rd_wb == rs1_exec) ? 2'b10 : 2'b00;
    assign fwd_b = (wen_mem && rd_mem != 5'd0 && rd_mem == rs2_exec) ? 2'b01 :
                   (wen_wb && rd_wb != 5'd0 && rd_wb == rs2_exec) ? 2'b10 : 2'b00;
    assign lu = load_exec && wen_exec && rd_exec != 5'd0 &&
                ((rs1_used_dec && rs1_dec == rd_exec) || (rs2_used_dec && rs2_dec == rd_exec));
    assign mw = dmem_req && !dmem_ready;
    // A memory wait entered from DRAIN still counts as draining on its release cycle
    assign draining = state_q == DRAIN || (state_q == MEMWAIT && from_drain_q);
    assign state       = state_q;
    assign halt_out    = halt_q;
    assign err_timeout = err_q;
    assign stall_count = stall_cnt_q;
    // Pipeline controls, prioritised halted > memory wait > redirect > drain/load-use
    always_comb begin
        stall_if    = 1'b0;
        stall_dec   = 1'b0;
        bubble_exec = 1'b0;
        flush_dec   = 1'b0;
        flush_exec  = 1'b0;
        flush_mem   = 1'b0;
        freeze      = 1'b0;
        fwd_a_sel   = 2'b00;
        fwd_b_sel   = 2'b00;
        if (!rst) begin
            if (state_q == HALTED) begin
                freeze    = 1'b1;
                stall_if  = 1'b1;
                stall_dec = 1'b1;
            end else begin
                fwd_a_sel = fwd_a;
                fwd_b_sel = fwd_b;
                if (mw) begin
                    freeze = 1'b1;
                end else if (redirect_mem) begin
                    flush_dec  = 1'b1;
                    flush_exec = 1'b1;
                    flush_mem  = 1'b1;
                end else begin
                    stall_if    = draining || lu;
                    flush_dec   = draining;
                    stall_dec   = lu;
                    bubble_exec = lu;
                end
            end
        end
    end
    // Next-state logic for the FSM, its counters and the sticky flags
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        drain_d      = drain_q;
        from_drain_d = from_drain_q;
        halt_d       = halt_q;
        err_d        = err_q;
        stall_cnt_d  = ((stall_dec || freeze || bubble_exec) && state_q != HALTED && stall_cnt_q != 16'hFFFF)
                       ? stall_cnt_q + 16'd1 : stall_cnt_q;
        case (state_q)
            RUN: begin
                if (mw) begin
                    state_d      = MEMWAIT;
                    wait_d       = WW'(1);
                    from_drain_d = 1'b0;
                end else if (halt_if && !redirect_mem) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            MEMWAIT: begin
                if (mw) begin
                    if (wait_q == WW'(MEM_TIMEOUT - 1)) begin
                        state_d = HALTED;
                        err_d   = 1'b1;
                        halt_d  = 1'b1;
                    end else begin
                        wait_d = wait_q + WW'(1);
                    end
                end else if (!from_drain_q) begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (mw) begin
                    state_d      = MEMWAIT;
                    wait_d       = WW'(1);
                    from_drain_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (draining && !mw) begin
            if (redirect_mem) begin
                state_d      = RUN;
                drain_d      = '0;
                from_drain_d = 1'b0;
            end else if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
                state_d = HALTED;
                halt_d  = 1'b1;
            end else begin
                state_d = DRAIN;
                drain_d = drain_q + DW'(1);
            end
        end
    end
    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            wait_q       <= '0;
            drain_q      <= '0;
            from_drain_q <= 1'b0;
            halt_q       <= 1'b0;
            err_q        <= 1'b0;
            stall_cnt_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            drain_q      <= drain_d;
            from_drain_q <= from_drain_d;
            halt_q       <= halt_d;
            err_q        <= err_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench with a behavioural model of the hazard controller
module tb_pipeline_hazard_ctrl;
    localparam int DC = 4;
    localparam int MT = 8;
    typedef struct packed {
        logic [6:0]  ctrl;
        logic [3:0]  fwd;
        logic        ho;
        logic        et;
        logic [1:0]  st;
        logic [15:0] sc;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] rs1_dec, rs2_dec, rs1_exec, rs2_exec, rd_exec, rd_mem, rd_wb;
    logic rs1_used_dec, rs2_used_dec, wen_exec, wen_mem, wen_wb, load_exec;
    logic redirect_mem, halt_if, dmem_req, dmem_ready;
    logic stall_if, stall_dec, bubble_exec, flush_dec, flush_exec, flush_mem, freeze;
    logic [1:0] fwd_a_sel, fwd_b_sel, state;
    logic halt_out, err_timeout;
    logic [15:0] stall_count;
    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int m_st, m_wait, m_left, m_cnt;
    bit m_resume, m_halt, m_err;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(DC), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .rst(rst),
        .rs1_dec(rs1_dec), .rs2_dec(rs2_dec), .rs1_used_dec(rs1_used_dec), .rs2_used_dec(rs2_used_dec),
        .rs1_exec(rs1_exec), .rs2_exec(rs2_exec), .rd_exec(rd_exec), .rd_mem(rd_mem), .rd_wb(rd_wb),
        .wen_exec(wen_exec), .wen_mem(wen_mem), .wen_wb(wen_wb), .load_exec(load_exec),
        .redirect_mem(redirect_mem), .halt_if(halt_if), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .stall_if(stall_if), .stall_dec(stall_dec), .bubble_exec(bubble_exec),
        .flush_dec(flush_dec), .flush_exec(flush_exec), .flush_mem(flush_mem), .freeze(freeze),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .halt_out(halt_out), .err_timeout(err_timeout),
        .state(state), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] fwd_of(input logic [4:0] rs);
        if (wen_mem && rd_mem != 0 && rd_mem == rs) return 2'b01;
        if (wen_wb && rd_wb != 0 && rd_wb == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_st = 0; m_wait = 0; m_left = 0; m_cnt = 0;
        m_resume = 0; m_halt = 0; m_err = 0;
    endtask

    task automatic step();
        exp_t e;
        bit lu, mw, drn, si, sd, be, fd, fe, fm, fz;
        e = '0;
        if (rst) begin
            model_reset();
        end else begin
            lu = load_exec && wen_exec && rd_exec != 0 &&
                 ((rs1_used_dec && rs1_dec == rd_exec) || (rs2_used_dec && rs2_dec == rd_exec));
            mw = dmem_req && !dmem_ready;
            drn = m_st == 2 || (m_st == 1 && m_resume);
            {si, sd, be, fd, fe, fm, fz} = '0;
            if (m_st == 3) {si, sd, fz} = 3'b111;
            else if (mw) fz = 1;
            else if (redirect_mem) {fd, fe, fm} = 3'b111;
            else begin
                si = drn || lu; fd = drn; sd = lu; be = lu;
            end
            e.ctrl = {si, sd, be, fd, fe, fm, fz};
            e.fwd = (m_st == 3) ? 4'b0 : {fwd_of(rs1_exec), fwd_of(rs2_exec)};
            e.ho = m_halt; e.et = m_err; e.st = 2'(m_st); e.sc = 16'(m_cnt);
            if ((sd || fz || be) && m_st != 3 && m_cnt < 65535) m_cnt++;
            if (m_st == 3) ;
            else if (mw) begin
                if (m_st == 1) begin
                    m_wait++;
                    if (m_wait == MT) begin m_st = 3; m_halt = 1; m_err = 1; end
                end else begin
                    m_resume = (m_st == 2); m_wait = 1; m_st = 1;
                end
            end else if (drn) begin
                if (redirect_mem) begin m_st = 0; m_resume = 0; end
                else begin
                    m_left--;
                    if (m_left == 0) begin m_st = 3; m_halt = 1; end else m_st = 2;
                end
            end else if (m_st == 1) m_st = 0;
            else if (m_st == 0 && halt_if && !redirect_mem) begin m_st = 2; m_left = DC; end
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        {rs1_dec, rs2_dec, rs1_exec, rs2_exec, rd_exec, rd_mem, rd_wb} = '0;
        {rs1_used_dec, rs2_used_dec, wen_exec, wen_mem, wen_wb, load_exec} = '0;
        {redirect_mem, halt_if, dmem_req, dmem_ready} = '0;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ctrl", 16'({stall_if, stall_dec, bubble_exec, flush_dec, flush_exec, flush_mem, freeze}), 16'(e.ctrl));
            chk("fwd", 16'({fwd_a_sel, fwd_b_sel}), 16'(e.fwd));
            chk("halt_out", 16'(halt_out), 16'(e.ho));
            chk("err_timeout", 16'(err_timeout), 16'(e.et));
            chk("state", 16'(state), 16'(e.st));
            chk("stall_count", stall_count, e.sc);
        end
    end

    initial begin
        clear_in();
        model_reset();
        @(posedge clk);
        #1;
        step();
        rst = 0;
        step();
        // load-use on x5, then released
        load_exec = 1; wen_exec = 1; rd_exec = 5; rs1_dec = 5; rs1_used_dec = 1;
        step();
        clear_in();
        step();
        // forwarding priority
        rd_mem = 7; rd_wb = 7; wen_mem = 1; wen_wb = 1; rs1_exec = 7; rs2_exec = 7;
        step();
        wen_mem = 0;
        step();
        rd_mem = 0; rd_wb = 0; wen_mem = 1;
        step();
        clear_in();
        // redirect together with load-use
        load_exec = 1; wen_exec = 1; rd_exec = 3; rs2_dec = 3; rs2_used_dec = 1; redirect_mem = 1;
        step();
        clear_in();
        // three-cycle memory wait with a redirect held across it
        dmem_req = 1; redirect_mem = 1;
        repeat (3) step();
        dmem_ready = 1;
        step();
        clear_in();
        step();
        // plain halt drain
        halt_if = 1;
        step();
        halt_if = 0;
        repeat (6) step();
        rst = 1; step(); rst = 0;
        // drain delayed by a two-cycle memory wait
        halt_if = 1; step(); halt_if = 0;
        step();
        dmem_req = 1;
        repeat (2) step();
        dmem_ready = 1;
        step();
        clear_in();
        repeat (5) step();
        rst = 1; step(); rst = 0;
        // redirect cancels a drain
        halt_if = 1; step(); halt_if = 0;
        step();
        redirect_mem = 1; step(); redirect_mem = 0;
        repeat (2) step();
        // memory-wait timeout
        dmem_req = 1;
        repeat (11) step();
        clear_in();
        rst = 1; step(); rst = 0;
        // asynchronous reset in the middle of a drain
        halt_if = 1; step(); halt_if = 0;
        repeat (2) step();
        load_exec = 1; wen_exec = 1; rd_exec = 2; rs1_dec = 2; rs1_used_dec = 1; rd_mem = 1; wen_mem = 1; rs1_exec = 1;
        rst = 1; step(); rst = 0;
        clear_in();
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rs1_dec = 5'($urandom_range(0, 3)); rs2_dec = 5'($urandom_range(0, 3));
            rs1_exec = 5'($urandom_range(0, 3)); rs2_exec = 5'($urandom_range(0, 3));
            rd_exec = 5'($urandom_range(0, 3)); rd_mem = 5'($urandom_range(0, 3)); rd_wb = 5'($urandom_range(0, 3));
            rs1_used_dec = 1'($urandom_range(0, 1)); rs2_used_dec = 1'($urandom_range(0, 1));
            wen_exec = 1'($urandom_range(0, 1)); wen_mem = 1'($urandom_range(0, 1)); wen_wb = 1'($urandom_range(0, 1));
            load_exec = $urandom_range(0, 9) < 3;
            redirect_mem = $urandom_range(0, 9) == 0;
            halt_if = $urandom_range(0, 19) == 0;
            dmem_req = $urandom_range(0, 9) < 3;
            dmem_ready = $urandom_range(0, 9) < 4;
            rst = (m_st == 3) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 0;
        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
